cpu_fetch: RTL and testbench

CPU_FETCH -- requirements
Module: cpu_fetch

---
 rtl/cpu_fetch.sv | 102 ++++++++++
 tb/tb_cpu_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch stage.
// Holds the program counter, drives the instruction memory address and
// registers the returned word into the decode-stage pipeline register.
// Precedence on every edge: idle, redirect, hazard hold, halted, normal fetch.

`ifndef HALT
`define HALT 5'b00001
`endif

module cpu_fetch #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter logic [15:0] NOP_IR   = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        state,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [7:0]  branch_target,
   input  logic [15:0] i_datain,
   output logic [7:0]  i_addr,
   output logic [15:0] id_ir,
   output logic [7:0]  id_pc,
   output logic        fetch_halted
);

   logic [7:0]  pcQ;
   logic [7:0]  pcD;
   logic [15:0] irQ;
   logic [15:0] irD;
   logic [7:0]  idPcQ;
   logic [7:0]  idPcD;
   logic        haltedQ;
   logic        haltedD;
   logic [4:0]  opcode;
   logic        isHalt;

   assign opcode = i_datain[15:11];
   assign isHalt = (opcode == `HALT);

   // The memory address is the pc itself so the instruction word comes back
   // within the same cycle; all other outputs come straight from registers,
   // which keeps i_datain away from every output combinationally.
   assign i_addr       = pcQ;
   assign id_ir        = irQ;
   assign id_pc        = idPcQ;
   assign fetch_halted = haltedQ;

   // Next-state selection. Idle forces the reset image, a redirect squashes
   // whatever was fetched this cycle (including a wrong-path HALT), a stall
   // freezes everything, and once halted the stage only emits bubbles while
   // parking the pc on the address after the HALT.
   always_comb begin
      pcD     = pcQ;
      irD     = irQ;
      idPcD   = idPcQ;
      haltedD = haltedQ;
      if (!state) begin
         pcD     = RESET_PC;
         irD     = NOP_IR;
         idPcD   = 8'h00;
         haltedD = 1'b0;
      end else if (branch_taken) begin
         pcD     = branch_target;
         irD     = NOP_IR;
         idPcD   = 8'h00;
         haltedD = 1'b0;
      end else if (stall) begin
         pcD     = pcQ;
         irD     = irQ;
         idPcD   = idPcQ;
         haltedD = haltedQ;
      end else if (haltedQ) begin
         pcD     = pcQ;
         irD     = NOP_IR;
         idPcD   = 8'h00;
         haltedD = 1'b1;
      end else begin
         pcD     = pcQ + 8'd1;
         irD     = i_datain;
         idPcD   = pcQ;
         haltedD = isHalt;
      end
   end

   // State registers; the active-low reset is asynchronous so it aborts any
   // fetch, stall or halt condition without waiting for a clock edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pcQ     <= RESET_PC;
         irQ     <= NOP_IR;
         idPcQ   <= 8'h00;
         haltedQ <= 1'b0;
      end else begin
         pcQ     <= pcD;
         irQ     <= irD;
         idPcQ   <= idPcD;
         haltedQ <= haltedD;
      end
   end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed bench for the fetch stage with a behavioural
// instruction memory that answers in the same cycle.

`ifndef HALT
`define HALT 5'b00001
`endif

module tb_cpu_fetch;

   logic        clock;
   logic        reset;
   logic        state;
   logic        stall;
   logic        branchTaken;
   logic [7:0]  branchTarget;
   logic [15:0] iDatain;
   logic [7:0]  iAddr;
   logic [15:0] idIr;
   logic [7:0]  idPc;
   logic        fetchHalted;

   logic [15:0] mem [0:255];
   int checks;
   int failures;

   cpu_fetch #(
      .RESET_PC (8'h00),
      .NOP_IR   (16'h0000)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .state         (state),
      .stall         (stall),
      .branch_taken  (branchTaken),
      .branch_target (branchTarget),
      .i_datain      (iDatain),
      .i_addr        (iAddr),
      .id_ir         (idIr),
      .id_pc         (idPc),
      .fetch_halted  (fetchHalted)
   );

   // Same-cycle instruction memory.
   assign iDatain = mem[iAddr];

   // Free-running clock, 10 time-unit period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [7:0] expAddr, input logic [15:0] expIr,
                           input logic [7:0] expPc, input logic expHalted);
      checkOutput({tag, ".i_addr"}, {8'h00, iAddr}, {8'h00, expAddr});
      checkOutput({tag, ".id_ir"}, idIr, expIr);
      checkOutput({tag, ".id_pc"}, {8'h00, idPc}, {8'h00, expPc});
      checkOutput({tag, ".halted"}, {15'h0, fetchHalted}, {15'h0, expHalted});
   endtask

   // Advance one edge and settle just after it.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      state        = 1'b0;
      stall        = 1'b0;
      branchTaken  = 1'b0;
      branchTarget = 8'h00;
      for (int n = 0; n < 256; n++) mem[n] = 16'h1000 + 16'(n);

      // Asynchronous reset before any clock edge.
      #2 reset = 1'b0;
      #1 checkAll("reset_async", 8'h00, 16'h0000, 8'h00, 1'b0);
      applyStimulus();
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      checkAll("idle_after_reset", 8'h00, 16'h0000, 8'h00, 1'b0);

      // Sequential run.
      state = 1'b1;
      checkOutput("seq_first_addr", {8'h00, iAddr}, 16'h0000);
      applyStimulus();
      checkAll("seq1", 8'h01, 16'h1000, 8'h00, 1'b0);
      applyStimulus();
      checkAll("seq2", 8'h02, 16'h1001, 8'h01, 1'b0);
      applyStimulus();
      checkAll("seq3", 8'h03, 16'h1002, 8'h02, 1'b0);
      applyStimulus();
      applyStimulus();
      checkAll("seq5", 8'h05, 16'h1004, 8'h04, 1'b0);

      // Stall for two cycles at pc 5, then branch while still stalled.
      stall = 1'b1;
      applyStimulus();
      checkAll("stall1", 8'h05, 16'h1004, 8'h04, 1'b0);
      applyStimulus();
      checkAll("stall2", 8'h05, 16'h1004, 8'h04, 1'b0);
      branchTaken  = 1'b1;
      branchTarget = 8'h40;
      applyStimulus();
      checkAll("branch_over_stall", 8'h40, 16'h0000, 8'h00, 1'b0);
      branchTaken = 1'b0;
      stall       = 1'b0;
      applyStimulus();
      checkAll("after_branch", 8'h41, 16'h1040, 8'h40, 1'b0);

      // pc wrap FE, FF, 00, 01.
      branchTaken  = 1'b1;
      branchTarget = 8'hFE;
      applyStimulus();
      checkAll("wrap_fe", 8'hFE, 16'h0000, 8'h00, 1'b0);
      branchTaken = 1'b0;
      applyStimulus();
      checkAll("wrap_ff", 8'hFF, 16'h10FE, 8'hFE, 1'b0);
      applyStimulus();
      checkAll("wrap_00", 8'h00, 16'h10FF, 8'hFF, 1'b0);
      applyStimulus();
      checkAll("wrap_01", 8'h01, 16'h1000, 8'h00, 1'b0);

      // HALT at address 3.
      mem[3] = {`HALT, 11'h003};
      state = 1'b0;
      applyStimulus();
      checkAll("halt_idle", 8'h00, 16'h0000, 8'h00, 1'b0);
      state = 1'b1;
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkAll("halt_pre", 8'h03, 16'h1002, 8'h02, 1'b0);
      applyStimulus();
      checkAll("halt_load", 8'h04, {`HALT, 11'h003}, 8'h03, 1'b1);
      applyStimulus();
      checkAll("halt_bubble1", 8'h04, 16'h0000, 8'h00, 1'b1);
      applyStimulus();
      checkAll("halt_bubble2", 8'h04, 16'h0000, 8'h00, 1'b1);
      state = 1'b0;
      applyStimulus();
      checkAll("halt_to_idle", 8'h00, 16'h0000, 8'h00, 1'b0);
      state = 1'b1;
      applyStimulus();
      checkAll("halt_restart", 8'h01, 16'h1000, 8'h00, 1'b0);

      // Wrong-path HALT at pc 1 squashed by a same-cycle branch.
      mem[1]       = {`HALT, 11'h001};
      branchTaken  = 1'b1;
      branchTarget = 8'h10;
      applyStimulus();
      checkAll("wrongpath", 8'h10, 16'h0000, 8'h00, 1'b0);
      branchTaken = 1'b0;
      applyStimulus();
      checkAll("wrongpath_next", 8'h11, 16'h1010, 8'h10, 1'b0);

      // Halt with pc parked at 22, stall while halted, then async reset.
      mem[8'h21]   = {`HALT, 11'h021};
      branchTaken  = 1'b1;
      branchTarget = 8'h21;
      applyStimulus();
      branchTaken = 1'b0;
      applyStimulus();
      checkAll("halt22_load", 8'h22, {`HALT, 11'h021}, 8'h21, 1'b1);
      stall = 1'b1;
      applyStimulus();
      checkAll("halt22_stall", 8'h22, {`HALT, 11'h021}, 8'h21, 1'b1);
      stall = 1'b0;
      applyStimulus();
      checkAll("halt22_bubble", 8'h22, 16'h0000, 8'h00, 1'b1);
      #2 reset = 1'b0;
      #1 checkAll("reset_mid", 8'h00, 16'h0000, 8'h00, 1'b0);
      state = 1'b0;
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      checkAll("reset_release_idle", 8'h00, 16'h0000, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
